codificador_gray: RTL and testbench
===================================

# codificador_gray

Streaming binary-to-Gray encoder: the transmit-side counterpart of the Gray-to-binary decoder in the pointer/data path. It accepts binary words on a valid/ready input and emits their Gray-coded form on a valid/ready output through a 2-entry registered skid buffer. Each output word is tagged with an adjacency flag, and a running count of emitted words is kept. It sits between the binary producer (counter or pointer logic) and the consumer that expects Gray-coded data.

## Interface
- WIDTH, 16, data width of binary input and Gray output (≥2)
- CNT_W, 16, width of emitted-word counter

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  binary word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  WIDTH  Gray word, g = b ^ (b >> 1)
- out_adj  output  1  out_data differs in exactly one bit from the previously emitted word
- out_count  output  CNT_W  number of words emitted since reset, wraps
- out_parity  output  1  even parity of the original binary word (only with CODIFICADOR_PARITY_EN)

## Operation
- Input handshake: word accepted on a rising edge where in_valid && in_ready. Output handshake: word emitted on a rising edge where out_valid && out_ready.
- Encoding at enqueue: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i+1] ^ b[i] for i < WIDTH-1. Stored with its adj flag (and parity bit when enabled).
- Buffer is a 2-entry FIFO. Occupancy states:
  - EMPTY: push → ONE.
  - ONE: push only → TWO; pop only → EMPTY; push+pop → ONE.
  - TWO: pop → ONE. Push is impossible because in_ready = 0.
- in_ready = (state != TWO). It is a registered function of state and never depends combinationally on in_valid or out_ready.
- out_valid = (state != EMPTY). out_data, out_adj and out_parity always show the head entry.
- Adjacency: a register last_g holds the Gray word of the most recent accepted input. A has_last flag is 0 after reset.
  - adj = has_last && popcount(g ^ last_g) == 1.
  - On accept: last_g ← g, has_last ← 1.
  - Because ordering is FIFO, this equals adjacency against the previously emitted word.
- out_count increments by 1 on each output handshake and wraps from 2^CNT_W−1 to 0.
- out_data, out_adj and out_parity must hold stable while out_valid && !out_ready.

## Timing
- Reset (rst_n low at a rising edge): state = EMPTY, in_ready = 1, out_valid = 0, out_data = 0, out_adj = 0, out_parity = 0, out_count = 0, last_g = 0, has_last = 0.
- Reset mid-operation discards all buffered words. Words are not emitted, counted or used for adj history. Any handshake on the reset edge is ignored.
- Latency: a word accepted at edge N has out_valid = 1 in the cycle after edge N. The minimum latency is 1 cycle, with no combinational path from input to output.
- Throughput: 1 word/cycle sustained while out_ready = 1.
- With out_ready = 0, the block absorbs 2 words, then in_ready drops in the cycle after the second accept.
- A push and a pop on the same edge in state ONE keeps occupancy at ONE. The new head is the pushed word, and out_count increments.

## Configuration
- CODIFICADOR_PARITY_EN defined:
  - out_parity port exists.
  - Each entry stores ^b of the original binary word, presented with its Gray word.
  - Resets to 0.
- Not defined: out_parity port and its storage are absent. All other behaviour is identical.

## Test plan
- Encoding, WIDTH = 16, out_ready = 1: push 0x0000, 0x0001, 0x0002, 0x8000, 0xFFFF → out_data 0x0000, 0x0001, 0x0003, 0xC000, 0x8000, each one cycle after accept. out_count ends at 5.
- Adjacency:
  - Push 5 then 6 → Gray 0x0007, 0x0005, out_adj 0 then 1.
  - After reset, push 5 then 9 → Gray 0x0007, 0x000D, out_adj 0 then 0.
- Backpressure:
  - Hold out_ready = 0 and push A, B, C back-to-back → A and B accepted, in_ready = 0 with C held on the input.
  - Raise out_ready → A, B, C emitted in order with no loss or duplication. out_data is stable while stalled.
- Random valid/ready on both sides, 10 000 words → output sequence equals Gray(input sequence), out_count = 10 000 mod 2^16.
- Counter wrap, CNT_W = 4: emit 17 words → out_count 0xF after 15, 0x0 after 16, 0x1 after 17.
- Reset mid-operation: with 2 words buffered, assert rst_n = 0 for one edge → out_valid = 0, out_count = 0, in_ready = 1. The next pushed word has out_adj = 0. With the macro, push 0x0003 → out_parity 0; push 0x0007 → out_parity 1.

Source files
------------

// File: rtl/codificador_gray.sv
// Streaming binary-to-Gray encoder with a 2-entry registered skid buffer,
// adjacency tagging and an emitted-word counter. Define CODIFICADOR_PARITY_EN to add out_parity.
module codificador_gray #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_adj,
    output logic [CNT_W-1:0] out_count
`ifdef CODIFICADOR_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] head_g_q, head_g_d;
    logic [WIDTH-1:0] tail_g_q, tail_g_d;
    logic             head_adj_q, head_adj_d;
    logic             tail_adj_q, tail_adj_d;
    logic [WIDTH-1:0] last_g_q, last_g_d;
    logic             has_last_q, has_last_d;
    logic [CNT_W-1:0] count_q, count_d;
`ifdef CODIFICADOR_PARITY_EN
    logic             head_par_q, head_par_d;
    logic             tail_par_q, tail_par_d;
    logic             enc_par;
`endif

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] enc_g;
    logic [WIDTH-1:0] diff;
    logic             enc_adj;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_g_q;
    assign out_adj   = head_adj_q;
    assign out_count = count_q;
`ifdef CODIFICADOR_PARITY_EN
    assign out_parity = head_par_q;
    assign enc_par    = ^in_data;
`endif

    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign enc_g   = in_data ^ (in_data >> 1);
    assign diff    = enc_g ^ last_g_q;
    // Adjacency is judged at enqueue; FIFO order makes it equal to output-side adjacency.
    assign enc_adj = has_last_q && ($countones(diff) == 1);

    always_comb begin
        state_d    = state_q;
        head_g_d   = head_g_q;
        tail_g_d   = tail_g_q;
        head_adj_d = head_adj_q;
        tail_adj_d = tail_adj_q;
        last_g_d   = last_g_q;
        has_last_d = has_last_q;
        count_d    = count_q;
`ifdef CODIFICADOR_PARITY_EN
        head_par_d = head_par_q;
        tail_par_d = tail_par_q;
`endif

        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_g_d   = enc_g;
                    head_adj_d = enc_adj;
`ifdef CODIFICADOR_PARITY_EN
                    head_par_d = enc_par;
`endif
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    tail_g_d   = enc_g;
                    tail_adj_d = enc_adj;
`ifdef CODIFICADOR_PARITY_EN
                    tail_par_d = enc_par;
`endif
                    state_d    = TWO;
                end else if (push && pop) begin
                    head_g_d   = enc_g;
                    head_adj_d = enc_adj;
`ifdef CODIFICADOR_PARITY_EN
                    head_par_d = enc_par;
`endif
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_g_d   = tail_g_q;
                    head_adj_d = tail_adj_q;
`ifdef CODIFICADOR_PARITY_EN
                    head_par_d = tail_par_q;
`endif
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (push) begin
            last_g_d   = enc_g;
            has_last_d = 1'b1;
        end
        if (pop) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_g_q   <= '0;
            tail_g_q   <= '0;
            head_adj_q <= 1'b0;
            tail_adj_q <= 1'b0;
            last_g_q   <= '0;
            has_last_q <= 1'b0;
            count_q    <= '0;
`ifdef CODIFICADOR_PARITY_EN
            head_par_q <= 1'b0;
            tail_par_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            head_g_q   <= head_g_d;
            tail_g_q   <= tail_g_d;
            head_adj_q <= head_adj_d;
            tail_adj_q <= tail_adj_d;
            last_g_q   <= last_g_d;
            has_last_q <= has_last_d;
            count_q    <= count_d;
`ifdef CODIFICADOR_PARITY_EN
            head_par_q <= head_par_d;
            tail_par_q <= tail_par_d;
`endif
        end
    end

endmodule

// File: tb/tb_codificador_gray.sv
// Self-checking bench for codificador_gray: vector table, directed corner sequences
// and randomized handshakes against a queue-based reference model.
module tb_codificador_gray;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        in_ready, out_valid, out_adj;
    logic [15:0] out_data, out_count;
    logic        in_ready4, out_valid4, out_adj4;
    logic [15:0] out_data4;
    logic [3:0]  out_count4;
`ifdef CODIFICADOR_PARITY_EN
    logic        out_parity, out_parity4;
`endif

    always #5 clk = ~clk;

    codificador_gray #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_adj(out_adj), .out_count(out_count)
`ifdef CODIFICADOR_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    codificador_gray #(.WIDTH(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_adj(out_adj4), .out_count(out_count4)
`ifdef CODIFICADOR_PARITY_EN
        , .out_parity(out_parity4)
`endif
    );

    typedef struct {
        logic [15:0] g;
        logic        adj;
        logic        par;
    } ent_t;

    typedef struct {
        logic        rst_before;
        int          prev_cnt;
        logic [15:0] b;
        logic [15:0] g;
        logic        adj;
    } vec_t;

    ent_t        mq[$];
    int unsigned cnt;
    logic [15:0] m_last_g;
    logic        m_has_last;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] gray_of(input logic [15:0] b);
        logic [15:0] g;
        g[15] = b[15];
        for (int i = 0; i < 15; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    function automatic int bits_set(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) if (v[i]) n++;
        return n;
    endfunction

    // One clock: check outputs against the model, then advance the model on the edge.
    task automatic cycle();
        bit   push, pop;
        ent_t e;
        chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("out_count", {16'd0, out_count}, cnt % 65536);
        chk("out_count4", {28'd0, out_count4}, cnt % 16);
        chk("in_ready4", {31'd0, in_ready4}, {31'd0, mq.size() < 2});
        chk("out_valid4", {31'd0, out_valid4}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk("out_data", {16'd0, out_data}, {16'd0, mq[0].g});
            chk("out_adj", {31'd0, out_adj}, {31'd0, mq[0].adj});
`ifdef CODIFICADOR_PARITY_EN
            chk("out_parity", {31'd0, out_parity}, {31'd0, mq[0].par});
`endif
        end
        push = in_valid && (mq.size() < 2);
        pop  = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            cnt = 0; m_last_g = '0; m_has_last = 1'b0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                cnt++;
            end
            if (push) begin
                e.g   = gray_of(in_data);
                e.adj = m_has_last && (bits_set(e.g ^ m_last_g) == 1);
                e.par = (bits_set(in_data) % 2) == 1;
                mq.push_back(e);
                m_last_g   = e.g;
                m_has_last = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit hs);
        rst_n = 1'b0; in_valid = hs; out_ready = hs; in_data = 16'h00FF;
        @(posedge clk);
        mq.delete();
        cnt = 0; m_last_g = '0; m_has_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_adj", {31'd0, out_adj}, 32'd0);
        chk("rst_out_count", {16'd0, out_count}, 32'd0);
        chk("rst_out_count4", {28'd0, out_count4}, 32'd0);
`ifdef CODIFICADOR_PARITY_EN
        chk("rst_out_parity", {31'd0, out_parity}, 32'd0);
`endif
    endtask

    vec_t        vt[9];
    logic [15:0] held;
    int          pushed, cyc;
    bit          acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        cnt = 0; m_last_g = '0; m_has_last = 1'b0;

        vt[0] = '{1'b1, 0, 16'h0000, 16'h0000, 1'b0};
        vt[1] = '{1'b0, 0, 16'h0001, 16'h0001, 1'b1};
        vt[2] = '{1'b0, 0, 16'h0002, 16'h0003, 1'b1};
        vt[3] = '{1'b0, 0, 16'h8000, 16'hC000, 1'b0};
        vt[4] = '{1'b0, 0, 16'hFFFF, 16'h8000, 1'b1};
        vt[5] = '{1'b1, 5, 16'h0005, 16'h0007, 1'b0};
        vt[6] = '{1'b0, 0, 16'h0006, 16'h0005, 1'b1};
        vt[7] = '{1'b1, 2, 16'h0005, 16'h0007, 1'b0};
        vt[8] = '{1'b0, 0, 16'h0009, 16'h000D, 1'b0};

        @(negedge clk);

        // Encoding and adjacency vectors, out_ready held high.
        for (int i = 0; i < 9; i++) begin
            if (vt[i].rst_before) begin
                if (i > 0) begin
                    in_valid = 1'b0;
                    cycle();
                    chk("grp_count", {16'd0, out_count}, vt[i].prev_cnt);
                end
                do_reset(1'b0);
            end
            out_ready = 1'b1; in_valid = 1'b1; in_data = vt[i].b;
            cycle();
            chk("vec_data", {16'd0, out_data}, {16'd0, vt[i].g});
            chk("vec_adj", {31'd0, out_adj}, {31'd0, vt[i].adj});
        end
        in_valid = 1'b0;
        cycle();

        // Backpressure: A and B absorbed, C held off, then released in order.
        do_reset(1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234; cycle();
        in_data = 16'hA5A5; cycle();
        in_data = 16'h0F0F;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        held = out_data;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_stall_stable", {16'd0, out_data}, {16'd0, held});
        end
        chk("bp_head_is_a", {16'd0, out_data}, 32'h1B2E);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            acc = (mq.size() < 2);
            cycle();
        end
        chk("bp_c_accepted", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        chk("bp_count", {16'd0, out_count}, 32'd3);

        // Counter wrap on the 4-bit instance.
        do_reset(1'b0);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 16'(i * 3);
            cycle();
            if (i == 15) chk("wrap_after15", {28'd0, out_count4}, 32'hF);
            if (i == 16) chk("wrap_after16", {28'd0, out_count4}, 32'h0);
        end
        in_valid = 1'b0;
        cycle();
        chk("wrap_after17", {28'd0, out_count4}, 32'h1);

        // Reset with two words buffered and a handshake on the reset edge.
        do_reset(1'b0);
        in_valid = 1'b1; in_data = 16'h0011; cycle();
        in_data = 16'h0012; cycle();
        chk("mid_two_buffered", {31'd0, in_ready}, 32'd0);
        do_reset(1'b1);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0003;
        cycle();
        chk("mid_adj_cleared", {31'd0, out_adj}, 32'd0);
        chk("mid_data3", {16'd0, out_data}, 32'h0002);
`ifdef CODIFICADOR_PARITY_EN
        chk("par_3", {31'd0, out_parity}, 32'd0);
`endif
        in_data = 16'h0007;
        cycle();
        chk("mid_data7", {16'd0, out_data}, 32'h0004);
`ifdef CODIFICADOR_PARITY_EN
        chk("par_7", {31'd0, out_parity}, 32'd1);
`endif
        in_valid = 1'b0;
        cycle();

        // Randomized handshakes on both sides.
        do_reset(1'b0);
        pushed = 0; cyc = 0;
        while ((pushed < 10000 || mq.size() > 0) && cyc < 60000) begin
            in_valid  = (pushed < 10000) && ($urandom_range(0, 9) < 7);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            if (in_valid && mq.size() < 2) pushed++;
            cycle();
            cyc++;
        end
        chk("rand_completed", {31'd0, cyc < 60000}, 32'd1);
        chk("rand_count", {16'd0, out_count}, 10000 % 65536);
        chk("rand_count4", {28'd0, out_count4}, 10000 % 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
